// File: rtl/obstacle_engine.sv
// Obstacle position/speed generator for the Dino Run 640x480 field.
// Ports: clk, rst (sync, active-low); obstacle_h/v (x/y), obstacle_hvel (px/tick).
module obstacle_engine #(
    parameter int TICK_DIV         = 833333,
    parameter int H_START          = 640,
    parameter int GROUND_V         = 400,
    parameter int AIR_V            = 360,
    parameter int INIT_VEL         = 2,
    parameter int MAX_VEL          = 20,
    parameter int PASSES_PER_LEVEL = 4,
    parameter int MIN_GAP          = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] obstacle_h,
    output logic [9:0] obstacle_v,
    output logic [5:0] obstacle_hvel
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;
    localparam int GW = $clog2(MIN_GAP + 16);

    typedef enum logic {
        MOVE,
        WAIT
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [PW-1:0] pass_cnt, pass_n;
    logic [GW-1:0] gap, gap_n;
    logic [7:0]    lfsr;
    logic [9:0]    h_n, v_n, vel_ext;
    logic [5:0]    vel_n;

    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign vel_ext = {4'b0, obstacle_hvel};

    // Frame tick divider and free-running random source
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
            lfsr     <= 8'hA5;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= MOVE;
            obstacle_h    <= 10'(H_START);
            obstacle_v    <= 10'(GROUND_V);
            obstacle_hvel <= 6'(INIT_VEL);
            pass_cnt      <= '0;
            gap           <= '0;
        end else begin
            state         <= state_n;
            obstacle_h    <= h_n;
            obstacle_v    <= v_n;
            obstacle_hvel <= vel_n;
            pass_cnt      <= pass_n;
            gap           <= gap_n;
        end
    end

    always_comb begin
        state_n = state;
        h_n     = obstacle_h;
        v_n     = obstacle_v;
        vel_n   = obstacle_hvel;
        pass_n  = pass_cnt;
        gap_n   = gap;
        if (tick) begin
            case (state)
                MOVE: begin
                    if (obstacle_h > vel_ext) begin
                        h_n = obstacle_h - vel_ext;
                    end else begin
                        // Pass finished: park off-screen and pick a gap
                        h_n     = 10'(H_START);
                        gap_n   = GW'(MIN_GAP) + GW'(lfsr[3:0]);
                        state_n = WAIT;
                        if (pass_cnt == PW'(PASSES_PER_LEVEL - 1)) begin
                            pass_n = '0;
                            if (obstacle_hvel < 6'(MAX_VEL))
                                vel_n = obstacle_hvel + 6'd1;
                        end else begin
                            pass_n = pass_cnt + PW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (gap != '0) begin
                        gap_n = gap - GW'(1);
                    end else begin
                        // Next obstacle flies when both top bits are set
                        state_n = MOVE;
                        v_n     = (lfsr[7:6] == 2'b11) ? 10'(AIR_V)
                                                       : 10'(GROUND_V);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_obstacle_engine.sv
// Scoreboard bench for obstacle_engine with a cycle-level reference model.
// Ports: drives clk/rst, checks obstacle_h, obstacle_v, obstacle_hvel.
module tb_obstacle_engine;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] obstacle_h;
    logic [9:0] obstacle_v;
    logic [5:0] obstacle_hvel;

    always #5 clk = ~clk;

    obstacle_engine #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .rst(rst),
        .obstacle_h(obstacle_h),
        .obstacle_v(obstacle_v),
        .obstacle_hvel(obstacle_hvel)
    );

    typedef struct {
        int h;
        int v;
        int vel;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    int m_h, m_v, m_vel, m_pass, m_gap, m_cyc, passes_done;
    bit m_wait;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    task automatic model_edge(input bit r);
        if (!r) begin
            m_h = 640; m_v = 400; m_vel = 2;
            m_pass = 0; m_gap = 0; m_cyc = 0;
            m_wait = 0; m_lfsr = 8'hA5;
        end else begin
            if (m_cyc % TD == TD - 1) begin
                if (!m_wait) begin
                    if (m_h > m_vel) begin
                        m_h = m_h - m_vel;
                    end else begin
                        m_h = 640;
                        m_gap = 8 + int'(m_lfsr[3:0]);
                        m_wait = 1;
                        passes_done++;
                        m_pass++;
                        if (m_pass == 4) begin
                            m_pass = 0;
                            m_vel = (m_vel + 1 > 20) ? 20 : m_vel + 1;
                        end
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else begin
                    m_wait = 0;
                    m_v = (m_lfsr[7:6] == 2'b11) ? 360 : 400;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_cyc++;
        end
    endtask

    task automatic step(input bit r);
        exp_t x;
        rst = r;
        model_edge(r);
        x.h = m_h; x.v = m_v; x.vel = m_vel;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic budget_fail(input string name);
        checks++;
        failures++;
        $display("FAIL budget_%s: condition not reached within cycle limit", name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obstacle_h !== 10'(e.h) || obstacle_v !== 10'(e.v) ||
                obstacle_hvel !== 6'(e.vel)) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL outputs t=%0t got h=%0d v=%0d vel=%0d expected h=%0d v=%0d vel=%0d",
                             $time, obstacle_h, obstacle_v, obstacle_hvel,
                             e.h, e.v, e.vel);
            end
        end
    end

    initial begin
        int n;
        int target;
        passes_done = 0;
        repeat (5) step(1'b0);

        n = 0;
        while (!(m_h <= 300 && !m_wait) && n < 4000) begin
            step(1'b1);
            n++;
        end
        if (n >= 4000) budget_fail("move300");
        repeat ($urandom_range(0, 7)) step(1'b1);
        repeat ($urandom_range(1, 3)) step(1'b0);

        n = 0;
        while (!m_wait && n < 6000) begin
            step(1'b1);
            n++;
        end
        if (n >= 6000) budget_fail("wait");
        repeat ($urandom_range(0, 20)) step(1'b1);
        repeat ($urandom_range(1, 3)) step(1'b0);

        n = 0;
        while (m_vel < 20 && n < 60000) begin
            step(1'b1);
            n++;
        end
        if (n >= 60000) budget_fail("saturate");
        target = passes_done + 4;
        n = 0;
        while (passes_done < target && n < 4000) begin
            step(1'b1);
            n++;
        end
        if (n >= 4000) budget_fail("extra_passes");
        repeat (200) step(1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
